regfile_multiport: RTL

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_dump_fsm.sv | 98 +++++++++
 rtl/regfile_multiport.sv | 98 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file and its dump engine:
//   - default data width, register count and read-port count
//   - dump engine state encoding
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NRD_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// ---------------------------------------------------------------------------
// regfile_dump_fsm
// Sequencer that walks register indices 0..NREGS-1 under a valid/ready
// handshake and pulses done one cycle after the last beat is accepted.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   one-cycle dump request (honoured only in IDLE)
//   ready  in   consumer accepts the current beat
//   valid  out  beat present (STREAM)
//   busy   out  engine not IDLE
//   done   out  one-cycle pulse after the final beat
//   idx    out  index of the current beat
// ---------------------------------------------------------------------------
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_e   state, state_next;
    logic [AW-1:0] count, count_next;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        count_next = count;
        valid      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    count_next = '0;
                end
            end
            STREAM: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (ready) begin
                    // NREGS is a power of two, so the increment after the
                    // last index wraps the counter back to 0 by itself.
                    count_next = count + AW'(1);
                    if (count == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs read as idle for the whole reset cycle, not only after the
        // reset edge has been taken.
        if (rst) begin
            valid = 1'b0;
            busy  = 1'b0;
            done  = 1'b0;
        end
    end

    assign idx = rst ? '0 : count;

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// Register file with one write port, NRD combinational read ports with
// write-first bypass, a hard-wired zero register 0, and a handshaked dump
// stream that reads out every register in ascending order.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   rsAddr       in   [NRD][AW]   read address per port
//   rsData       out  [NRD][XLEN] read data per port (combinational)
//   rd           in   [AW]        write address
//   writeEnable  in   write strobe
//   data         in   [XLEN]      write data
//   dumpStart    in   one-cycle dump request
//   dumpReady    in   consumer accepts dump beat
//   dumpValid    out  dump beat present
//   dumpIdx      out  [AW]        index of current beat
//   dumpData     out  [XLEN]      value of current beat
//   dumpBusy     out  dump engine active
//   dumpDone     out  one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rsAddr,
    output logic [NRD-1:0][XLEN-1:0] rsData,
    input  logic [AW-1:0]            rd,
    input  logic                     writeEnable,
    input  logic [XLEN-1:0]          data,
    input  logic                     dumpStart,
    input  logic                     dumpReady,
    output logic                     dumpValid,
    output logic [AW-1:0]            dumpIdx,
    output logic [XLEN-1:0]          dumpData,
    output logic                     dumpBusy,
    output logic                     dumpDone
);

    logic [XLEN-1:0] regs [NREGS];
    logic            write_hit;

    assign write_hit = writeEnable && (rd != '0);

    // NOTE: the array is built from flops rather than a RAM macro because
    // reset must clear every register; a plain RAM would carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[rd] <= data;
        end
    end

    // Read ports: register 0 forced to zero, then write-first bypass, then
    // the array. The bypass is suppressed during reset since that write is
    // discarded.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rsData[p] = '0;
            if (!rst && rsAddr[p] != '0) begin
                if (write_hit && rsAddr[p] == rd) begin
                    rsData[p] = data;
                end else begin
                    rsData[p] = regs[rsAddr[p]];
                end
            end
        end
    end

    regfile_dump_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (dumpStart),
        .ready (dumpReady),
        .valid (dumpValid),
        .busy  (dumpBusy),
        .done  (dumpDone),
        .idx   (dumpIdx)
    );

    // Dump beats read the array directly with no bypass: a beat shows what
    // the array holds on its transfer cycle.
    assign dumpData = (dumpValid && dumpIdx != '0) ? regs[dumpIdx] : '0;

endmodule
